// File: rtl/credit_link_tx.sv
// credit_link_tx: local flit FIFO feeding a credit-flow-controlled router channel.
// Define CREDIT_LINK_TX_PKT_COUNT_EN to build the transmitted-packet counter.
module credit_link_tx #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int CREDITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  credit_in,
  output logic                  credit_err,
  output logic                  drop_err,
  output logic [15:0]           packet_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;

  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PACKET_FLITS - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_DROP = 2'b10;

  logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  rdy_en_q;
  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic                  cred_ovf;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic                  out_valid_q;
  logic                  credit_err_q;
  logic                  drop_err_q;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  launch;
  logic                  drop_pop;
  logic                  last_flit;
  logic                  drop_done;
  logic [FLIT_WIDTH-1:0] head;

  // Returns {overflow, next_count}; a take and a give in the same cycle cancel out.
  function automatic logic [CW:0] credit_update(input logic [CW-1:0] cur,
                                                input logic          take,
                                                input logic          give);
    logic [CW:0] res;
    res = {1'b0, cur};
    if (take && !give) begin
      res = {1'b0, cur - CW'(1)};
    end else if (give && !take) begin
      if (cur == CRED_MAX) res = {1'b1, cur};
      else                 res = {1'b0, cur + CW'(1)};
    end
    return res;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign head       = mem_q[rd_ptr_q];

  // Ready comes from registers only and stays low until the first edge after reset.
  assign in_ready = rdy_en_q & ~fifo_full;
  assign wr_en    = in_valid & in_ready;

  assign launch    = (state_q == S_SEND) && !fifo_empty && (cred_q != '0);
  assign drop_pop  = (state_q == S_DROP) && !fifo_empty;
  assign rd_en     = launch | drop_pop;
  assign last_flit = (idx_q == IDX_LAST);
  assign drop_done = drop_pop & last_flit;

  assign wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

  assign {cred_ovf, cred_d} = credit_update(cred_q, launch, credit_in);

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + (AW+1)'(1);
    else if (rd_en && !wr_en) count_d = count_q - (AW+1)'(1);
  end

  // The header is only inspected in IDLE; it is popped as index 0 of SEND or DROP.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = (head[FLIT_WIDTH-1 -: 2] == 2'b10) ? S_SEND : S_DROP;
        end
      end
      S_SEND, S_DROP: begin
        if (rd_en) begin
          if (last_flit) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rdy_en_q     <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cred_q       <= CRED_MAX;
      out_flit_q   <= '0;
      out_valid_q  <= 1'b0;
      credit_err_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rdy_en_q     <= 1'b1;
      state_q      <= state_d;
      idx_q        <= idx_d;
      cred_q       <= cred_d;
      out_valid_q  <= launch;
      if (launch) out_flit_q <= head;
      credit_err_q <= credit_err_q | cred_ovf;
      drop_err_q   <= drop_err_q | drop_done;
    end
  end

  // Buffer storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_flit;
  end

  assign out_flit   = out_flit_q;
  assign out_valid  = out_valid_q;
  assign credit_err = credit_err_q;
  assign drop_err   = drop_err_q;

`ifdef CREDIT_LINK_TX_PKT_COUNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = (launch && last_flit) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign packet_count = pkt_cnt_q;
`else
  assign packet_count = 16'd0;
`endif

endmodule

// File: tb/tb_credit_link_tx.sv
// Scoreboard bench for credit_link_tx: directed scenarios followed by randomized packet traffic.
`timescale 1ns/1ps
module tb_credit_link_tx;

  localparam int FW = 32;
  localparam int PF = 5;
  localparam int FD = 8;
  localparam int CR = 4;
`ifdef CREDIT_LINK_TX_PKT_COUNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          credit_in;
  logic          credit_auto;
  logic          credit_man;
  logic          credit_err;
  logic          drop_err;
  logic [15:0]   packet_count;

  assign credit_in = credit_auto | credit_man;

  credit_link_tx #(
    .FLIT_WIDTH  (FW),
    .PACKET_FLITS(PF),
    .FIFO_DEPTH  (FD),
    .CREDITS     (CR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .credit_in   (credit_in),
    .credit_err  (credit_err),
    .drop_err    (drop_err),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          out_cycs[$];
  int          n_out = 0;
  int          outstanding = 0;
  int          m_idx = 0;
  int          m_pkts = 0;
  int          m_drops = 0;
  bit          m_keep = 1'b0;
  int          hdr_edge = 0;
  bit          auto_credit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] exp_pc(input int n);
    return PC_EN ? 32'(n % 65536) : 32'd0;
  endfunction

  // Packet-level reference: a packet is forwarded iff its header starts with 2'b10.
  function automatic void model_accept(input logic [31:0] f);
    if (m_idx == 0) begin
      m_keep   = (f[31:30] == 2'b10);
      hdr_edge = cyc + 1;
    end
    if (m_keep) exp_q.push_back(f);
    if (m_idx == PF - 1) begin
      m_idx = 0;
      if (m_keep) m_pkts++;
      else        m_drops++;
    end else begin
      m_idx++;
    end
  endfunction

  // Monitor: inputs are stable between edges, so the negedge view predicts the next transfer.
  always @(negedge clk) begin
    if (reset === 1'b1 && in_valid && in_ready === 1'b1) model_accept(in_flit);
    if (out_valid === 1'b1) begin
      n_out++;
      outstanding++;
      out_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: actual %0h required no flit", out_flit);
      end else begin
        check("out_flit", out_flit, exp_q.pop_front());
      end
      if (auto_credit) check("outstanding_le_credits", 32'(outstanding <= CR), 32'd1);
    end
  end

  // Downstream model: returns one credit per received flit after a random delay.
  initial begin
    credit_auto = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_credit && reset && outstanding > 0 && $urandom_range(0, 3) != 0) begin
        credit_auto = 1'b1;
        outstanding--;
      end else begin
        credit_auto = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_flit    = '0;
    credit_man = 1'b0;
    exp_q.delete();
    out_cycs.delete();
    n_out       = 0;
    outstanding = 0;
    m_idx       = 0;
    m_pkts      = 0;
    m_drops     = 0;
    m_keep      = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit", out_flit, 32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_packet_count", 32'(packet_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_first_edge", 32'(in_ready), 32'd1);
  endtask

  task automatic send_flit(input logic [31:0] f, input int maxw, output bit ok);
    ok       = 1'b0;
    in_flit  = f;
    in_valid = 1'b1;
    for (int n = 0; n < maxw && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] hdr, input int gapmax, output int nacc);
    bit          ok;
    logic [31:0] f;
    nacc = 0;
    for (int i = 0; i < PF; i++) begin
      f = (i == 0) ? hdr : $urandom();
      send_flit(f, 100, ok);
      if (ok) nacc++;
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic credit_pulse();
    credit_man = 1'b1;
    @(posedge clk);
    #1;
    credit_man = 1'b0;
    wait_cycles(3);
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: actual %0d flits pending required 0", name, exp_q.size());
    end
    wait_cycles(6);
  endtask

  function automatic logic [31:0] good_hdr();
    return {2'b10, 30'($urandom())};
  endfunction

  initial begin
    logic [31:0] pk [PF];
    logic [1:0]  top;
    int          acc;
    int          nacc;
    bit          ok;
    logic [31:0] f;
    int          guard;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_flit    = '0;
    credit_man = 1'b0;
    pk[0] = 32'h8A59_2D2D;
    pk[1] = 32'h4441_5431;
    pk[2] = 32'h4441_5432;
    pk[3] = 32'h4441_5433;
    pk[4] = 32'h4441_5434;

    // Single packet with credits always returning.
    do_reset();
    credit_man = 1'b1;
    acc = 0;
    for (int i = 0; i < PF; i++) begin
      send_flit(pk[i], 20, ok);
      if (ok) acc++;
    end
    wait_cycles(15);
    credit_man = 1'b0;
    check("s1_accepted", acc, PF);
    check("s1_out_count", n_out, PF);
    if (out_cycs.size() >= PF) begin
      check("s1_first_latency", out_cycs[0] - hdr_edge, 2);
      check("s1_back_to_back", out_cycs[PF-1] - out_cycs[0], PF - 1);
    end
    check("s1_packet_count", 32'(packet_count), exp_pc(1));

    // Two packets with no credits, then six single credits.
    do_reset();
    acc = 0;
    for (int p = 0; p < 2; p++) begin
      send_packet(good_hdr(), 0, nacc);
      acc += nacc;
    end
    check("s2_accepted", acc, 2 * PF);
    wait_cycles(20);
    check("s2_out_no_credit", n_out, CR);
    repeat (6) credit_pulse();
    wait_cycles(20);
    check("s2_out_after_credits", n_out, 2 * PF);
    check("s2_packet_count", 32'(packet_count), exp_pc(2));
    check("s2_credit_err", 32'(credit_err), 32'd0);

    // Continuous offer with no credits: buffer plus credits worth of flits accepted.
    do_reset();
    acc = 0;
    for (int i = 0; i < FD + CR + 1; i++) begin
      f = (i % PF == 0) ? good_hdr() : $urandom();
      send_flit(f, 10, ok);
      if (ok) acc++;
    end
    check("s3_accepted", acc, FD + CR);
    check("s3_in_ready_full", 32'(in_ready), 32'd0);
    check("s3_out_count", n_out, CR);

    // Malformed packet dropped, following valid packet forwarded.
    do_reset();
    auto_credit = 1'b1;
    send_packet(32'h0000_0001, 0, nacc);
    acc = nacc;
    send_packet(good_hdr(), 0, nacc);
    acc += nacc;
    wait_drain(200, "s4");
    auto_credit = 1'b0;
    check("s4_accepted", acc, 2 * PF);
    check("s4_drop_err", 32'(drop_err), 32'd1);
    check("s4_out_count", n_out, PF);
    check("s4_packet_count", 32'(packet_count), exp_pc(1));
    check("s4_credit_err", 32'(credit_err), 32'd0);

    // Credit overflow while idle must not raise the credit count above its maximum.
    do_reset();
    credit_pulse();
    check("s5_credit_err", 32'(credit_err), 32'd1);
    send_packet(good_hdr(), 0, nacc);
    wait_cycles(15);
    check("s5_out_capped", n_out, CR);

    // Credit arriving together with the launch that spends the last credit.
    do_reset();
    send_packet(good_hdr(), 0, nacc);
    guard = 0;
    while (cyc < hdr_edge + 4 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("s5_pulse_alignment", cyc - hdr_edge, 4);
    credit_man = 1'b1;
    @(posedge clk);
    #1;
    credit_man = 1'b0;
    send_packet(good_hdr(), 0, nacc);
    wait_cycles(20);
    check("s5_simultaneous_credit", n_out, PF);
    check("s5_no_err", 32'(credit_err), 32'd0);

    // Reset in the middle of a packet, then a fresh packet.
    do_reset();
    auto_credit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = (i == 0) ? good_hdr() : $urandom();
      send_flit(f, 20, ok);
    end
    wait_cycles(4);
    do_reset();
    send_packet(good_hdr(), 1, nacc);
    wait_drain(200, "s6");
    check("s6_accepted", nacc, PF);
    check("s6_out_count", n_out, PF);
    check("s6_packet_count", 32'(packet_count), exp_pc(1));
    check("s6_credit_err", 32'(credit_err), 32'd0);

    // Randomized traffic: mixed good and malformed packets, random gaps and credit delays.
    do_reset();
    auto_credit = 1'b1;
    acc = 0;
    for (int p = 0; p < 40; p++) begin
      if (p == 3 || $urandom_range(0, 4) == 0) begin
        top = 2'($urandom_range(0, 2));
        if (top == 2'b10) top = 2'b11;
        f = {top, 30'($urandom())};
      end else begin
        f = good_hdr();
      end
      send_packet(f, 2, nacc);
      acc += nacc;
    end
    wait_drain(2000, "rand");
    check("rand_accepted", acc, 40 * PF);
    check("rand_out_count", n_out, m_pkts * PF);
    check("rand_packet_count", 32'(packet_count), exp_pc(m_pkts));
    check("rand_drop_err", 32'(drop_err), 32'(m_drops > 0));
    check("rand_credit_err", 32'(credit_err), 32'd0);
    auto_credit = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
